// File: rtl/fb_scan_reader_if.sv
// Output stream of the frame scan reader: one word per handshake,
// with start-of-frame and end-of-line markers riding alongside.
interface fb_scan_reader_if #(
  parameter int unsigned DATA_WIDTH = 15
);
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_sof;
  logic                  out_eol;

  modport master (
    output out_data,
    output out_valid,
    output out_sof,
    output out_eol,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_sof,
    input  out_eol,
    output out_ready
  );
endinterface

// File: rtl/fb_scan_reader.sv
// Read-side sequencer for the frame/result RAM. Sweeps addresses
// 0..FRAME_WORDS-1 on a start pulse, absorbs the one-cycle RAM read latency
// through a 2-entry FIFO and presents the words as a valid/ready stream.
module fb_scan_reader #(
  parameter int unsigned ADDRESS_WIDTH = 20,
  parameter int unsigned DATA_WIDTH    = 15,
  parameter int unsigned FRAME_WORDS   = 307200,
  parameter int unsigned LINE_WORDS    = 640
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  fb_scan_reader_if.master         stream
);

  // One extra bit so a frame filling the whole address space does not alias.
  localparam int unsigned CNT_W = ADDRESS_WIDTH + 1;
  localparam int unsigned COL_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_WORDS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;

  logic [CNT_W-1:0]         issue_addr_q;
  logic [ADDRESS_WIDTH-1:0] rd_addr_q;
  logic                     pend_q;

  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;

  logic [CNT_W-1:0] out_idx_q;
  logic [COL_W-1:0] col_q;

  logic       out_valid_c;
  logic       pop_c;
  logic       issue_c;
  logic       clear_issue_c;
  logic [2:0] occupancy_c;

  assign out_valid_c = (count_q != 2'd0);
  assign pop_c       = out_valid_c & stream.out_ready;

  // Next-state logic, issue decision and busy/done updates.
  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    issue_c       = 1'b0;
    clear_issue_c = 1'b0;
    // Words that will occupy the FIFO after this edge, before any new issue.
    occupancy_c   = 3'(count_q) + 3'(pend_q) - 3'(pop_c);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = RUN;
          busy_d        = 1'b1;
          clear_issue_c = 1'b1;
        end
      end
      RUN: begin
        issue_c = (occupancy_c < 3'd2);
        if (issue_c && (issue_addr_q == LAST_IDX)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop_c && (out_idx_q == LAST_IDX)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with busy flag and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Issue address counter, last-issued address and read-pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_addr_q <= '0;
      rd_addr_q    <= '0;
      pend_q       <= 1'b0;
    end else begin
      pend_q <= issue_c;
      if (clear_issue_c) begin
        issue_addr_q <= '0;
      end else if (issue_c) begin
        issue_addr_q <= issue_addr_q + CNT_W'(1);
        rd_addr_q    <= issue_addr_q[ADDRESS_WIDTH-1:0];
      end
    end
  end

  // Two-entry FIFO capturing RAM data the cycle after each issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (pend_q) begin
        fifo_q[wr_ptr_q] <= rd_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_c) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(pend_q) - 2'(pop_c);
    end
  end

  // Output word index and column counters, advanced only on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_idx_q <= '0;
      col_q     <= '0;
    end else if (pop_c) begin
      out_idx_q <= (out_idx_q == LAST_IDX) ? '0 : out_idx_q + CNT_W'(1);
      col_q     <= (col_q == LAST_COL) ? '0 : col_q + COL_W'(1);
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = issue_c;
  assign rd_addr = issue_c ? issue_addr_q[ADDRESS_WIDTH-1:0] : rd_addr_q;

  assign stream.out_valid = out_valid_c;
  assign stream.out_data  = fifo_q[rd_ptr_q];
  assign stream.out_sof   = out_valid_c && (out_idx_q == '0);
  assign stream.out_eol   = out_valid_c && (col_q == LAST_COL);

endmodule

// File: tb/tb_fb_scan_reader.sv
// Directed bench for fb_scan_reader: an 8-word/4-per-line instance and a
// 4-word/1-per-line instance, each fed by a RAM model with mem[i] = i + 0x100.
module tb_fb_scan_reader;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start, busy, done, rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;

  logic          start2, busy2, done2, rd_en2;
  logic [AW-1:0] rd_addr2;
  logic [DW-1:0] rd_data2 = '0;

  fb_scan_reader_if #(.DATA_WIDTH(DW)) st ();
  fb_scan_reader_if #(.DATA_WIDTH(DW)) st2 ();

  fb_scan_reader #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_WORDS(8), .LINE_WORDS(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .stream(st)
  );

  fb_scan_reader #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_WORDS(4), .LINE_WORDS(1)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2), .stream(st2)
  );

  // RAM models with one-cycle registered read.
  always @(posedge clk) if (rd_en)  rd_data  <= DW'(rd_addr  + AW'(32'h100));
  always @(posedge clk) if (rd_en2) rd_data2 <= DW'(rd_addr2 + AW'(32'h100));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_busy"},      32'(busy), 0);
    check({pfx, "_done"},      32'(done), 0);
    check({pfx, "_rd_en"},     32'(rd_en), 0);
    check({pfx, "_rd_addr"},   32'(rd_addr), 0);
    check({pfx, "_out_valid"}, 32'(st.out_valid), 0);
    check({pfx, "_out_sof"},   32'(st.out_sof), 0);
    check({pfx, "_out_eol"},   32'(st.out_eol), 0);
    check({pfx, "_out_data"},  32'(st.out_data), 0);
  endtask

  // mode 0: ready high; 1: ready pattern 1,0,0,1; 2: ready low for 10 cycles.
  // stop_after > 0 returns mid-frame right after that many words handshake.
  task automatic run_frame(input int mode, input bit repulse, input int stop_after);
    int widx = 0, issued = 0, cnt_m = 0, pend_m = 0;
    int first_valid = -1, done_cyc = -1, issued_at9 = -1;
    bit done_exp = 0, fin = 0, r, pop, stalled = 0;
    logic [DW-1:0] prev_data = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (c % 4 == 0) || (c % 4 == 3);
        default: r = (c >= 10);
      endcase
      st.out_ready = r;
      start = repulse && (c == 3);
      #1;
      pop = st.out_valid && r;
      check("rd_en", 32'(rd_en), 32'((issued < 8) && (cnt_m + pend_m - int'(pop) < 2)));
      if (rd_en) begin
        check("rd_addr", 32'(rd_addr), 32'(issued));
        issued++;
      end
      check("out_valid", 32'(st.out_valid), 32'(cnt_m != 0));
      if (st.out_valid) begin
        if (first_valid < 0) first_valid = c;
        check("out_data", 32'(st.out_data), 32'(widx + 'h100));
        check("out_sof",  32'(st.out_sof),  32'(widx == 0));
        check("out_eol",  32'(st.out_eol),  32'(widx % 4 == 3));
        if (stalled) check("stall_stable", 32'(st.out_data), 32'(prev_data));
      end
      stalled   = st.out_valid && !r;
      prev_data = st.out_data;
      check("done", 32'(done), 32'(done_exp));
      check("busy", 32'(busy), 32'(!done_exp));
      if (done_exp) begin
        done_cyc = c;
        fin      = 1'b1;
      end
      if (c == 9) issued_at9 = issued;
      done_exp = pop && (widx == 7);
      if (pop) widx++;
      cnt_m  = cnt_m + pend_m - int'(pop);
      pend_m = int'(rd_en);
      if (stop_after > 0 && widx == stop_after) begin
        start = 1'b0;
        return;
      end
      if (!fin) step();
    end
    start = 1'b0;
    check("frame_finished", 32'(fin), 1);
    check("words_delivered", 32'(widx), 8);
    check("reads_issued", 32'(issued), 8);
    if (mode == 0) begin
      check("first_valid_cycle", 32'(first_valid), 2);
      check("done_cycle", 32'(done_cyc), 10);
    end
    if (mode == 2) check("reads_while_stalled", 32'(issued_at9), 2);
    step();
    #1;
    check("done_one_cycle", 32'(done), 0);
    check("busy_after_done", 32'(busy), 0);
    check("rd_en_idle", 32'(rd_en), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int widx2;
    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    st.out_ready = 1'b0;
    st2.out_ready = 1'b0;
    step();
    step();
    #1;
    check_reset_vals("por");
    rst = 1'b0;
    step();

    run_frame(0, 1'b0, 0);
    run_frame(1, 1'b1, 0);
    run_frame(2, 1'b0, 0);
    run_frame(0, 1'b0, 0);

    // Reset in the middle of a frame with a read in flight.
    run_frame(0, 1'b0, 4);
    rst = 1'b1;
    step();
    #1;
    check_reset_vals("mid_rst");
    rst = 1'b0;
    step();
    #1;
    check("post_rst_no_valid", 32'(st.out_valid), 0);
    run_frame(0, 1'b0, 0);

    // One word per line: every word ends a line.
    widx2 = 0;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    st2.out_ready = 1'b1;
    for (int c = 0; c < 40 && widx2 < 4; c++) begin
      #1;
      if (st2.out_valid) begin
        check("lw1_data", 32'(st2.out_data), 32'(widx2 + 'h100));
        check("lw1_sof",  32'(st2.out_sof),  32'(widx2 == 0));
        check("lw1_eol",  32'(st2.out_eol),  1);
        widx2++;
      end
      step();
    end
    check("lw1_words", 32'(widx2), 4);
    #1;
    check("lw1_done", 32'(done2), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
